intr_ctx_ctrl: RTL

//  Interrupt context controller: the save/restore sequencer for the MCU flag registers.

---
 rtl/mcu_pkg.sv | 14 +
 rtl/intr_sync.sv | 32 +++
 rtl/intr_ctx_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared MCU types and defaults.
// Contents: flags_t (the C/Z flag pair), default interrupt nesting depth
// and default synchronizer length.
package mcu_pkg;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  localparam int unsigned INTR_DEPTH_DFLT = 4;
  localparam int unsigned SYNC_STAGES_DFLT = 2;

endpackage : mcu_pkg

// File: rtl/intr_sync.sv
// Multi-flop synchronizer for an asynchronous line plus a rising-edge detector.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   d_i      asynchronous input line
//   rise_c   one-cycle pulse when the synchronized line goes 0->1 (combinational)
module intr_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift chain; prev_q holds the last stage delayed one cycle for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : intr_sync

// File: rtl/intr_ctx_ctrl.sv
// Interrupt context controller: synchronizes the external interrupt line, raises
// INT_REQ, and saves/restores C/Z on a DEPTH-deep flag stack so ISRs can nest.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   INTR_IN            asynchronous interrupt line
//   FLG_LD, C_IN, Z_IN ALU flag load
//   SEI, CLI           set / clear interrupt enable
//   INT_ACK            ISR entry pulse (push)
//   RETIE, RETID       ISR return (pop), with / without re-enabling I
//   C_FLAG, Z_FLAG, I_FLAG  current flags
//   INT_REQ            pending & I_FLAG
//   NEST_LVL           stack occupancy 0..DEPTH
//   CTX_ERR            sticky overflow / underflow / ACK+RET collision
module intr_ctx_ctrl
  import mcu_pkg::*;
#(
  parameter int unsigned DEPTH       = INTR_DEPTH_DFLT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DFLT,
  localparam int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INTR_IN,
  input  logic             FLG_LD,
  input  logic             C_IN,
  input  logic             Z_IN,
  input  logic             SEI,
  input  logic             CLI,
  input  logic             INT_ACK,
  input  logic             RETIE,
  input  logic             RETID,
  output logic             C_FLAG,
  output logic             Z_FLAG,
  output logic             I_FLAG,
  output logic             INT_REQ,
  output logic [LVL_W-1:0] NEST_LVL,
  output logic             CTX_ERR
);

  flags_t             flags_q, flags_d;
  flags_t             stack_q [DEPTH];
  flags_t             stack_d [DEPTH];
  flags_t             push_val;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               i_q, i_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic               rise;
  logic               ret;

  intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (CLK),
    .rst_i  (RST),
    .d_i    (INTR_IN),
    .rise_c (rise)
  );

  assign ret = RETIE | RETID;

  // Next-state: ACK > RET > FLG_LD > SEI/CLI.
  always_comb begin
    flags_d  = flags_q;
    stack_d  = stack_q;
    lvl_d    = lvl_q;
    i_d      = i_q;
    err_d    = err_q;
    push_val = FLG_LD ? flags_t'({C_IN, Z_IN}) : flags_q;
    // A new edge in the ACK cycle keeps the request pending.
    pend_d   = rise | (pend_q & ~INT_ACK);

    if (INT_ACK) begin
      i_d = 1'b0;
      if (FLG_LD) flags_d = flags_t'({C_IN, Z_IN});
      if (ret) err_d = 1'b1;
      if (lvl_q == LVL_W'(DEPTH)) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (lvl_q == LVL_W'(k)) stack_d[k] = push_val;
        end
        lvl_d = lvl_q + LVL_W'(1);
      end
    end else if (ret) begin
      // RETID dominates when both returns are asserted.
      i_d = RETIE & ~RETID;
      if (lvl_q == '0) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (lvl_q == LVL_W'(k + 1)) flags_d = stack_q[k];
        end
        lvl_d = lvl_q - LVL_W'(1);
      end
    end else begin
      if (FLG_LD) flags_d = flags_t'({C_IN, Z_IN});
      if (CLI) i_d = 1'b0;
      else if (SEI) i_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= '0;
      lvl_q   <= '0;
      i_q     <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) stack_q[k] <= '0;
    end else begin
      flags_q <= flags_d;
      lvl_q   <= lvl_d;
      i_q     <= i_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign C_FLAG   = flags_q.c;
  assign Z_FLAG   = flags_q.z;
  assign I_FLAG   = i_q;
  assign INT_REQ  = pend_q & i_q;
  assign NEST_LVL = lvl_q;
  assign CTX_ERR  = err_q;

endmodule : intr_ctx_ctrl
